// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the IF/MEM stages, the arbiter and the memory port.
interface imem_dmem_arbiter_if;
  // fetch side
  logic        if_req_ip;
  logic [31:0] if_addr_ip;
  logic        if_abort_ip;
  logic        if_gnt_op;
  logic        if_rvalid_op;
  logic [31:0] if_rdata_op;
  // data side
  logic        dm_req_ip;
  logic        dm_we_ip;
  logic [3:0]  dm_be_ip;
  logic [31:0] dm_addr_ip;
  logic [31:0] dm_wdata_ip;
  logic        dm_gnt_op;
  logic        dm_rvalid_op;
  logic [31:0] dm_rdata_op;
  // memory side
  logic        mem_req_op;
  logic        mem_we_op;
  logic [3:0]  mem_be_op;
  logic [31:0] mem_addr_op;
  logic [31:0] mem_wdata_op;
  logic        mem_rvalid_ip;
  logic [31:0] mem_rdata_ip;

  // Arbiter view.
  modport master (
    input  if_req_ip, if_addr_ip, if_abort_ip,
    output if_gnt_op, if_rvalid_op, if_rdata_op,
    input  dm_req_ip, dm_we_ip, dm_be_ip, dm_addr_ip, dm_wdata_ip,
    output dm_gnt_op, dm_rvalid_op, dm_rdata_op,
    output mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
    input  mem_rvalid_ip, mem_rdata_ip
  );

  // Pipeline-stage / memory-model view.
  modport slave (
    output if_req_ip, if_addr_ip, if_abort_ip,
    input  if_gnt_op, if_rvalid_op, if_rdata_op,
    output dm_req_ip, dm_we_ip, dm_be_ip, dm_addr_ip, dm_wdata_ip,
    input  dm_gnt_op, dm_rvalid_op, dm_rdata_op,
    input  mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
    output mem_rvalid_ip, mem_rdata_ip
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Single-outstanding DRAM port arbiter: data first, fetch starvation-bounded,
// flushed fetch responses dropped.
module imem_dmem_arbiter #(
  parameter int unsigned MAX_IF_WAIT = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  imem_dmem_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;

  localparam logic [CNT_W-1:0] MaxWait = CNT_W'(MAX_IF_WAIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt, starve_d;
  logic              drop_flag, drop_d;
  logic              dm_store_q, dm_store_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;

  logic              if_eff;
  logic              if_gnt, dm_gnt, mem_req, mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_addr, mem_wdata;

  assign if_eff = bus.if_req_ip & ~bus.if_abort_ip;

  // State and registered response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      starve_cnt  <= '0;
      drop_flag   <= 1'b0;
      dm_store_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_cnt  <= starve_d;
      drop_flag   <= drop_d;
      dm_store_q  <= dm_store_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Arbitration, next state and same-cycle grant/memory request.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_cnt;
    drop_d      = drop_flag;
    dm_store_d  = dm_store_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_be      = 4'h0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (bus.dm_req_ip && (starve_cnt < MaxWait)) begin
          dm_gnt     = 1'b1;
          mem_req    = 1'b1;
          mem_we     = bus.dm_we_ip;
          mem_be     = bus.dm_be_ip;
          mem_addr   = bus.dm_addr_ip;
          mem_wdata  = bus.dm_wdata_ip;
          dm_store_d = bus.dm_we_ip;
          state_d    = DM_WAIT;
          // data only wins below MaxWait, so this saturates at MaxWait
          if (if_eff) starve_d = CNT_W'(starve_cnt + 1'b1);
        end else if (if_eff) begin
          if_gnt   = 1'b1;
          mem_req  = 1'b1;
          mem_be   = 4'hF;
          mem_addr = bus.if_addr_ip;
          starve_d = '0;
          drop_d   = 1'b0;
          state_d  = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (bus.if_abort_ip) drop_d = 1'b1;
        if (bus.mem_rvalid_ip) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!drop_flag && !bus.if_abort_ip) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata_ip;
          end
        end
      end
      DM_WAIT: begin
        if (bus.mem_rvalid_ip) begin
          state_d     = IDLE;
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = dm_store_q ? 32'h0 : bus.mem_rdata_ip;
        end
      end
      default: state_d = IDLE;
    endcase

    // Combinational outputs are forced low while reset is asserted.
    if (!reset) begin
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
    end
  end

  assign bus.if_gnt_op    = if_gnt;
  assign bus.dm_gnt_op    = dm_gnt;
  assign bus.mem_req_op   = mem_req;
  assign bus.mem_we_op    = mem_we;
  assign bus.mem_be_op    = mem_be;
  assign bus.mem_addr_op  = mem_addr;
  assign bus.mem_wdata_op = mem_wdata;
  assign bus.if_rvalid_op = if_rvalid_q;
  assign bus.if_rdata_op  = if_rdata_q;
  assign bus.dm_rvalid_op = dm_rvalid_q;
  assign bus.dm_rdata_op  = dm_rdata_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed testbench for imem_dmem_arbiter.
module tb_imem_dmem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  imem_dmem_arbiter_if bus();

  imem_dmem_arbiter #(.MAX_IF_WAIT(4), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req_ip     = 1'b0;
    bus.if_addr_ip    = 32'h0;
    bus.if_abort_ip   = 1'b0;
    bus.dm_req_ip     = 1'b0;
    bus.dm_we_ip      = 1'b0;
    bus.dm_be_ip      = 4'h0;
    bus.dm_addr_ip    = 32'h0;
    bus.dm_wdata_ip   = 32'h0;
    bus.mem_rvalid_ip = 1'b0;
    bus.mem_rdata_ip  = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    bus.dm_req_ip  = 1'b1;
    bus.if_req_ip  = 1'b1;
    bus.dm_addr_ip = 32'h55;
    #12;
    if (bus.dm_gnt_op !== 1'b0) begin errors++; $display("FAIL rst_dm_gnt: got %b want 0", bus.dm_gnt_op); end checks++;
    if (bus.if_gnt_op !== 1'b0) begin errors++; $display("FAIL rst_if_gnt: got %b want 0", bus.if_gnt_op); end checks++;
    if (bus.mem_req_op !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req_op); end checks++;
    if (bus.mem_addr_op !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr_op); end checks++;
    if (bus.if_rvalid_op !== 1'b0 || bus.dm_rvalid_op !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", bus.if_rvalid_op, bus.dm_rvalid_op); end checks++;
    if (bus.if_rdata_op !== 32'h0 || bus.dm_rdata_op !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", bus.if_rdata_op, bus.dm_rdata_op); end checks++;
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    tick();
    if (bus.mem_req_op !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b want 0", bus.mem_req_op); end checks++;
  endtask

  task automatic test_single_fetch();
    bus.if_req_ip  = 1'b1;
    bus.if_addr_ip = 32'h100;
    #1;
    if (bus.if_gnt_op !== 1'b1) begin errors++; $display("FAIL sf_gnt: got %b want 1", bus.if_gnt_op); end checks++;
    if (bus.mem_req_op !== 1'b1 || bus.mem_addr_op !== 32'h100) begin errors++; $display("FAIL sf_mem: got req=%b addr=%h want 1/100", bus.mem_req_op, bus.mem_addr_op); end checks++;
    if (bus.mem_we_op !== 1'b0 || bus.mem_be_op !== 4'hF) begin errors++; $display("FAIL sf_we_be: got we=%b be=%h want 0/f", bus.mem_we_op, bus.mem_be_op); end checks++;
    tick();
    bus.if_req_ip = 1'b0;
    if (bus.mem_req_op !== 1'b0 || bus.if_gnt_op !== 1'b0) begin errors++; $display("FAIL sf_wait_quiet: got req=%b gnt=%b want 0/0", bus.mem_req_op, bus.if_gnt_op); end checks++;
    tick();
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'h00500093;
    if (bus.if_rvalid_op !== 1'b0) begin errors++; $display("FAIL sf_early_rvalid: got %b want 0", bus.if_rvalid_op); end checks++;
    tick();
    bus.mem_rvalid_ip = 1'b0;
    if (bus.if_rvalid_op !== 1'b1 || bus.if_rdata_op !== 32'h00500093) begin errors++; $display("FAIL sf_resp: got v=%b d=%h want 1/00500093", bus.if_rvalid_op, bus.if_rdata_op); end checks++;
    tick();
    if (bus.if_rvalid_op !== 1'b0 || bus.if_rdata_op !== 32'h00500093) begin errors++; $display("FAIL sf_pulse_hold: got v=%b d=%h want 0/00500093", bus.if_rvalid_op, bus.if_rdata_op); end checks++;
  endtask

  task automatic test_simultaneous();
    bus.if_req_ip   = 1'b1;
    bus.if_addr_ip  = 32'h104;
    bus.dm_req_ip   = 1'b1;
    bus.dm_we_ip    = 1'b1;
    bus.dm_be_ip    = 4'b0011;
    bus.dm_addr_ip  = 32'h2000;
    bus.dm_wdata_ip = 32'hDEADBEEF;
    #1;
    if (bus.dm_gnt_op !== 1'b1 || bus.if_gnt_op !== 1'b0) begin errors++; $display("FAIL sim_prio: got dm=%b if=%b want 1/0", bus.dm_gnt_op, bus.if_gnt_op); end checks++;
    if (bus.mem_we_op !== 1'b1 || bus.mem_be_op !== 4'b0011) begin errors++; $display("FAIL sim_we_be: got we=%b be=%h want 1/3", bus.mem_we_op, bus.mem_be_op); end checks++;
    if (bus.mem_addr_op !== 32'h2000 || bus.mem_wdata_op !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_addr_wdata: got %h/%h want 2000/deadbeef", bus.mem_addr_op, bus.mem_wdata_op); end checks++;
    tick();
    bus.dm_req_ip = 1'b0;
    if (bus.if_gnt_op !== 1'b0 || bus.mem_req_op !== 1'b0) begin errors++; $display("FAIL sim_holdoff: got gnt=%b req=%b want 0/0", bus.if_gnt_op, bus.mem_req_op); end checks++;
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'hCAFEF00D;
    tick();
    bus.mem_rvalid_ip = 1'b0;
    if (bus.dm_rvalid_op !== 1'b1 || bus.dm_rdata_op !== 32'h0) begin errors++; $display("FAIL sim_store_ack: got v=%b d=%h want 1/0", bus.dm_rvalid_op, bus.dm_rdata_op); end checks++;
    if (bus.if_gnt_op !== 1'b1 || bus.mem_addr_op !== 32'h104) begin errors++; $display("FAIL sim_fetch_next: got gnt=%b addr=%h want 1/104", bus.if_gnt_op, bus.mem_addr_op); end checks++;
    tick();
    bus.if_req_ip     = 1'b0;
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'h00000011;
    tick();
    bus.mem_rvalid_ip = 1'b0;
    if (bus.if_rvalid_op !== 1'b1 || bus.if_rdata_op !== 32'h11) begin errors++; $display("FAIL sim_fetch_resp: got v=%b d=%h want 1/11", bus.if_rvalid_op, bus.if_rdata_op); end checks++;
    tick();
  endtask

  task automatic test_starvation();
    bus.dm_req_ip  = 1'b1;
    bus.dm_we_ip   = 1'b0;
    bus.dm_be_ip   = 4'hF;
    bus.dm_addr_ip = 32'h3000;
    bus.if_req_ip  = 1'b1;
    bus.if_addr_ip = 32'h108;
    for (int k = 1; k <= 4; k++) begin
      #1;
      if (bus.dm_gnt_op !== 1'b1 || bus.if_gnt_op !== 1'b0) begin errors++; $display("FAIL starve_arb%0d: got dm=%b if=%b want 1/0", k, bus.dm_gnt_op, bus.if_gnt_op); end checks++;
      if (k > 1 && bus.dm_rdata_op !== 32'(k - 1)) begin errors++; $display("FAIL starve_load%0d: got %h want %h", k, bus.dm_rdata_op, k - 1); end checks++;
      tick();
      bus.mem_rvalid_ip = 1'b1;
      bus.mem_rdata_ip  = 32'(k);
      tick();
      bus.mem_rvalid_ip = 1'b0;
    end
    #1;
    if (bus.if_gnt_op !== 1'b1 || bus.dm_gnt_op !== 1'b0) begin errors++; $display("FAIL starve_arb5: got if=%b dm=%b want 1/0", bus.if_gnt_op, bus.dm_gnt_op); end checks++;
    if (bus.mem_addr_op !== 32'h108) begin errors++; $display("FAIL starve_addr: got %h want 108", bus.mem_addr_op); end checks++;
    tick();
    if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt); end checks++;
    bus.if_req_ip     = 1'b0;
    bus.dm_req_ip     = 1'b0;
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'hF00D0005;
    tick();
    bus.mem_rvalid_ip = 1'b0;
    if (bus.if_rvalid_op !== 1'b1 || bus.if_rdata_op !== 32'hF00D0005) begin errors++; $display("FAIL starve_fetch_resp: got v=%b d=%h want 1/f00d0005", bus.if_rvalid_op, bus.if_rdata_op); end checks++;
    tick();
  endtask

  task automatic test_flush_drop();
    bus.if_req_ip  = 1'b1;
    bus.if_addr_ip = 32'h200;
    #1;
    if (bus.if_gnt_op !== 1'b1) begin errors++; $display("FAIL fl_gnt: got %b want 1", bus.if_gnt_op); end checks++;
    tick();
    bus.if_req_ip   = 1'b0;
    bus.if_abort_ip = 1'b1;
    tick();
    bus.if_abort_ip   = 1'b0;
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'h12345678;
    tick();
    bus.mem_rvalid_ip = 1'b0;
    if (bus.if_rvalid_op !== 1'b0 || bus.if_rdata_op !== 32'hF00D0005) begin errors++; $display("FAIL fl_dropped: got v=%b d=%h want 0/f00d0005", bus.if_rvalid_op, bus.if_rdata_op); end checks++;
    bus.if_req_ip  = 1'b1;
    bus.if_addr_ip = 32'h300;
    #1;
    if (bus.if_gnt_op !== 1'b1 || bus.mem_addr_op !== 32'h300) begin errors++; $display("FAIL fl_next_gnt: got gnt=%b addr=%h want 1/300", bus.if_gnt_op, bus.mem_addr_op); end checks++;
    tick();
    bus.if_req_ip     = 1'b0;
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'hABCD0001;
    tick();
    bus.mem_rvalid_ip = 1'b0;
    if (bus.if_rvalid_op !== 1'b1 || bus.if_rdata_op !== 32'hABCD0001) begin errors++; $display("FAIL fl_next_resp: got v=%b d=%h want 1/abcd0001", bus.if_rvalid_op, bus.if_rdata_op); end checks++;
    // abort coinciding with the response
    bus.if_req_ip  = 1'b1;
    bus.if_addr_ip = 32'h400;
    tick();
    bus.if_req_ip     = 1'b0;
    bus.if_abort_ip   = 1'b1;
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'h0BADF00D;
    tick();
    bus.if_abort_ip   = 1'b0;
    bus.mem_rvalid_ip = 1'b0;
    if (bus.if_rvalid_op !== 1'b0 || bus.if_rdata_op !== 32'hABCD0001) begin errors++; $display("FAIL fl_same_cycle: got v=%b d=%h want 0/abcd0001", bus.if_rvalid_op, bus.if_rdata_op); end checks++;
    tick();
  endtask

  task automatic test_abort_idle();
    bus.dm_req_ip  = 1'b1;
    bus.dm_we_ip   = 1'b0;
    bus.dm_addr_ip = 32'h40;
    bus.if_req_ip  = 1'b1;
    bus.if_addr_ip = 32'h500;
    tick();
    bus.dm_req_ip     = 1'b0;
    bus.if_req_ip     = 1'b0;
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'h66;
    tick();
    bus.mem_rvalid_ip = 1'b0;
    if (dut.starve_cnt !== 3'd1) begin errors++; $display("FAIL ai_starve_pre: got %0d want 1", dut.starve_cnt); end checks++;
    bus.if_req_ip   = 1'b1;
    bus.if_abort_ip = 1'b1;
    #1;
    if (bus.if_gnt_op !== 1'b0 || bus.mem_req_op !== 1'b0 || bus.mem_addr_op !== 32'h0) begin errors++; $display("FAIL ai_no_gnt: got gnt=%b req=%b addr=%h want 0/0/0", bus.if_gnt_op, bus.mem_req_op, bus.mem_addr_op); end checks++;
    tick();
    if (dut.starve_cnt !== 3'd1) begin errors++; $display("FAIL ai_starve_hold: got %0d want 1", dut.starve_cnt); end checks++;
    bus.dm_req_ip  = 1'b1;
    bus.dm_addr_ip = 32'h44;
    #1;
    if (bus.dm_gnt_op !== 1'b1 || bus.if_gnt_op !== 1'b0) begin errors++; $display("FAIL ai_dm_wins: got dm=%b if=%b want 1/0", bus.dm_gnt_op, bus.if_gnt_op); end checks++;
    tick();
    bus.dm_req_ip     = 1'b0;
    bus.if_req_ip     = 1'b0;
    bus.if_abort_ip   = 1'b1;
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'h77;
    tick();
    bus.if_abort_ip = 1'b0;
    if (dut.starve_cnt !== 3'd1) begin errors++; $display("FAIL ai_starve_aborted: got %0d want 1", dut.starve_cnt); end checks++;
    if (bus.dm_rvalid_op !== 1'b1 || bus.dm_rdata_op !== 32'h77) begin errors++; $display("FAIL ai_dm_resp: got v=%b d=%h want 1/77", bus.dm_rvalid_op, bus.dm_rdata_op); end checks++;
    // mem_rvalid_ip still high in IDLE is spurious
    bus.mem_rdata_ip = 32'h88;
    tick();
    bus.mem_rvalid_ip = 1'b0;
    if (bus.dm_rvalid_op !== 1'b0 || bus.if_rvalid_op !== 1'b0 || bus.dm_rdata_op !== 32'h77) begin errors++; $display("FAIL ai_spurious: got dv=%b iv=%b d=%h want 0/0/77", bus.dm_rvalid_op, bus.if_rvalid_op, bus.dm_rdata_op); end checks++;
  endtask

  task automatic test_reset_mid();
    bus.dm_req_ip  = 1'b1;
    bus.dm_we_ip   = 1'b0;
    bus.dm_addr_ip = 32'h3000;
    #1;
    if (bus.dm_gnt_op !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b want 1", bus.dm_gnt_op); end checks++;
    tick();
    bus.dm_req_ip = 1'b0;
    #2;
    reset = 1'b0;
    bus.dm_req_ip = 1'b1;
    bus.if_req_ip = 1'b1;
    #1;
    if (bus.dm_gnt_op !== 1'b0 || bus.if_gnt_op !== 1'b0 || bus.mem_req_op !== 1'b0) begin errors++; $display("FAIL rm_gnt_off: got dm=%b if=%b req=%b want 0/0/0", bus.dm_gnt_op, bus.if_gnt_op, bus.mem_req_op); end checks++;
    if (bus.mem_addr_op !== 32'h0 || bus.mem_be_op !== 4'h0) begin errors++; $display("FAIL rm_mem_off: got addr=%h be=%h want 0/0", bus.mem_addr_op, bus.mem_be_op); end checks++;
    if (bus.dm_rdata_op !== 32'h0 || bus.if_rdata_op !== 32'h0) begin errors++; $display("FAIL rm_rdata_off: got %h/%h want 0/0", bus.dm_rdata_op, bus.if_rdata_op); end checks++;
    if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL rm_starve: got %0d want 0", dut.starve_cnt); end checks++;
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    tick();
    bus.mem_rvalid_ip = 1'b1;
    bus.mem_rdata_ip  = 32'h99;
    tick();
    bus.mem_rvalid_ip = 1'b0;
    if (bus.dm_rvalid_op !== 1'b0 || bus.if_rvalid_op !== 1'b0 || bus.dm_rdata_op !== 32'h0) begin errors++; $display("FAIL rm_late_rvalid: got dv=%b iv=%b d=%h want 0/0/0", bus.dm_rvalid_op, bus.if_rvalid_op, bus.dm_rdata_op); end checks++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_flush_drop();
    test_abort_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares the single DRAM port between two requesters: the IF stage (instruction fetch) and the MEM stage (data load/store).
- Enforces one outstanding transaction at a time.
- Gives data accesses priority, with a bounded-starvation guarantee for fetch.
- Discards fetch responses killed by a branch flush.
- Sits between the IF/MEM stages and the memory model; the fetch-side grant feeds the IF stage's instruction grant input.

Parameters:
- MAX_IF_WAIT, 4: number of consecutive IDLE cycles the fetch side may lose arbitration before it is forced to win.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > MAX_IF_WAIT.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req_ip  in  1  fetch request; held until granted.
- if_addr_ip  in  32  fetch address.
- if_abort_ip  in  1  flush from EX; kills the pending or outstanding fetch.
- if_gnt_op  out  1  fetch request accepted this cycle.
- if_rvalid_op  out  1  fetch data valid (1-cycle pulse).
- if_rdata_op  out  32  fetch data.
- dm_req_ip  in  1  data request; held until granted.
- dm_we_ip  in  1  1 = store, 0 = load.
- dm_be_ip  in  4  byte enables.
- dm_addr_ip  in  32  data address.
- dm_wdata_ip  in  32  store data.
- dm_gnt_op  out  1  data request accepted this cycle.
- dm_rvalid_op  out  1  load data or store acknowledge (1-cycle pulse).
- dm_rdata_op  out  32  load data; 0 for stores.
- mem_req_op  out  1  request to memory.
- mem_we_op  out  1  write enable to memory.
- mem_be_op  out  4  byte enables to memory.
- mem_addr_op  out  32  address to memory.
- mem_wdata_op  out  32  write data to memory.
- mem_rvalid_ip  in  1  memory response valid; asserted for both reads and writes; latency ≥1 cycle, variable.
- mem_rdata_ip  in  32  memory read data.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state = IDLE, starve_cnt = 0, drop_flag = 0.
  - All outputs 0: gnt, rvalid, rdata, and all mem_* outputs.
- **States:** IDLE, IF_WAIT, DM_WAIT.
- **IDLE arbitration (combinational, same cycle):**
  - The fetch request is effective only when if_req_ip=1 and if_abort_ip=0.
  - Data wins if dm_req_ip=1 and starve_cnt < MAX_IF_WAIT. Otherwise an effective fetch request wins.
  - The winner's gnt is asserted in the same cycle.
  - mem_req_op=1 in the same cycle, with mem_* driven from the winner's inputs. For a fetch, mem_we_op=0 and mem_be_op=4'hF.
  - Next edge: state goes to IF_WAIT or DM_WAIT.
  - No request: gnt=0, mem_req_op=0, mem_addr_op=0, stay IDLE.
- **starve_cnt (updated in IDLE only):**
  - Increments (saturating) on each cycle an effective fetch request loses to data.
  - Clears when fetch is granted.
  - Holds in the WAIT states.
- **In the WAIT states:**
  - Both gnt outputs are 0 and mem_req_op=0.
  - Incoming requests are held off.
- **Response routing:**
  - On mem_rvalid_ip=1 in X_WAIT, the owner's rvalid/rdata are registered and appear on the next edge, as a single-cycle pulse.
  - dm_rdata_op = mem_rdata_ip for loads, 0 for stores.
  - On the same edge, state returns to IDLE. A new grant is possible in the cycle rvalid is high.
  - rdata outputs hold their last value; rvalid returns to 0 the following cycle.
- **Abort:**
  - if_abort_ip=1 in IF_WAIT sets drop_flag.
  - When the response arrives, if_rvalid_op stays 0, state goes to IDLE, and drop_flag clears.
  - if_abort_ip has no effect in DM_WAIT or on data traffic.
  - Abort in the same cycle as mem_rvalid_ip also drops the response.
- **Spurious input:** mem_rvalid_ip in IDLE is ignored.
- **Reset mid-transaction:** the response is abandoned. A late mem_rvalid_ip then arrives in IDLE and is ignored.

Test Plan:
- **Single fetch:** if_req_ip=1, addr=0x100, memory latency 2.
  - if_gnt_op=1 in cycle 0, with mem_addr_op=0x100, mem_we_op=0, mem_be_op=4'hF.
  - mem_rvalid_ip=1 in cycle 2 with data 0x00500093.
  - if_rvalid_op=1 in cycle 3 with if_rdata_op=0x00500093.
- **Simultaneous requests:**
  - if_req_ip=1 (0x104) and dm_req_ip=1, store 0xDEADBEEF to 0x2000, be=4'b0011.
  - dm_gnt_op wins first with mem_we_op=1 and mem_be_op=4'b0011.
  - dm_rvalid_op pulses with dm_rdata_op=0.
  - Next IDLE cycle: if_gnt_op for 0x104.
- **Starvation bound (MAX_IF_WAIT=4):**
  - dm_req_ip held high continuously, if_req_ip held high, latency 1.
  - The fetch is granted on the 5th IDLE arbitration.
  - starve_cnt reads 0 after that grant.
- **Flush drop:**
  - Fetch 0x200 granted; if_abort_ip=1 one cycle later; response 0x12345678 arrives.
  - if_rvalid_op never asserts; state returns to IDLE.
  - A following fetch to 0x300 is granted and returns normally.
- **Abort in IDLE:**
  - if_req_ip=1 and if_abort_ip=1 together, no data request.
  - No grant, mem_req_op=0, starve_cnt unchanged.
- **Async reset mid-op:**
  - Assert reset=0 between clock edges during DM_WAIT: all outputs go to 0 immediately.
  - After release, a late mem_rvalid_ip=1 produces no rvalid on either side.
